// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer built around one 16-bit ripple-carry slice.
// Operands are captured on start and processed one 16-bit word per clock, LSW first,
// with the inter-word carry held in a register. Subtraction is a + ~b + 1.
module multiword_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  sub_i,
  input  logic [16*WORDS-1:0]   a_i,
  input  logic [16*WORDS-1:0]   b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [16*WORDS-1:0]   result_o,
  output logic                  c_out_o,
  output logic                  overflow_o
);

  localparam int unsigned W    = 16 * WORDS;
  localparam int unsigned IdxW = $clog2(WORDS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            c_out_q, c_out_d;
  logic            ovf_q, ovf_d;

  logic [15:0]     a_word;
  logic [15:0]     bx_word;
  logic [15:0]     s_word;
  logic            cy;

  // Adder slice: selects the current word and forms a + (b ^ sub) + carry.
  always_comb begin
    a_word          = a_q[{idx_q, 4'b0000} +: 16];
    bx_word         = b_q[{idx_q, 4'b0000} +: 16] ^ {16{sub_q}};
    {cy, s_word}    = {1'b0, a_word} + {1'b0, bx_word} + {16'b0, carry_q};
  end

  // Next-state logic for the sequencer and the result/flag registers.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sub_d   = sub_i;
          // Seeding the carry with sub supplies the +1 of the two's complement.
          carry_d = sub_i;
          idx_d   = '0;
          state_d = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        result_d[{idx_q, 4'b0000} +: 16] = s_word;
        carry_d = cy;
        if (idx_q == LastIdx) begin
          c_out_d = cy;
          // Signed overflow: like-signed slice inputs giving a differently-signed sum.
          ovf_d   = (a_word[15] == bx_word[15]) && (s_word[15] != a_word[15]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy_o     = (state_q == StRun);
    done_o     = (state_q == StDone);
    result_o   = result_q;
    c_out_o    = c_out_q;
    overflow_o = ovf_q;
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (WORDS=4, 64-bit operands).
// A behavioural model computes each operation with plain 64-bit arithmetic and tracks
// the expected busy/done timing; a negedge compare process checks the DUT every cycle.
module tb_multiword_add_seq;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        c_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  multiword_add_seq #(
    .WORDS(WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .sub_i     (sub),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .c_out_o   (c_out),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {overflow, carry/no-borrow, result} of the full-width operation.
  function automatic logic [65:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                         input logic s);
    logic [63:0] r;
    logic        c;
    logic        o;
    if (s) begin
      r = x - y;
      c = (x >= y);
      o = (x[63] != y[63]) && (r[63] != x[63]);
    end else begin
      r = x + y;
      c = (r < x);
      o = (x[63] == y[63]) && (r[63] != x[63]);
    end
    return {o, c, r};
  endfunction

  // Model: phase 0 ready, 1..WORDS busy, WORDS+1 done.
  int          m_phase = 0;
  logic [63:0] m_res = '0;
  logic        m_cout = 1'b0;
  logic        m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
    end else if ((m_phase == 0 || m_phase == WORDS + 1) && start) begin
      m_phase <= 1;
      {m_ovf, m_cout, m_res} <= ref_op(a, b, sub);
    end else if (m_phase == WORDS + 1) begin
      m_phase <= 0;
    end else if (m_phase > 0) begin
      m_phase <= m_phase + 1;
    end
  end

  // Compare DUT with model on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(busy), 64'(m_phase >= 1 && m_phase <= WORDS));
      chk("done", 64'(done), 64'(m_phase == WORDS + 1));
      if (m_phase == WORDS + 1) begin
        chk("model_result", result, m_res);
        chk("model_c_out", 64'(c_out), 64'(m_cout));
        chk("model_overflow", 64'(overflow), 64'(m_ovf));
      end
    end
  end

  // One operation with hand-computed expectations; also pins the model itself.
  task automatic op_lit(input logic [63:0] x, input logic [63:0] y, input logic s,
                        input logic [63:0] er, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: got no done expected done within 20 cycles");
    end else begin
      chk("latency", 64'(n), 64'(WORDS));
      chk("lit_result", result, er);
      chk("lit_c_out", 64'(c_out), 64'(ec));
      chk("lit_overflow", 64'(overflow), 64'(eo));
      chk("model_pin", {m_res[63:2], m_res[1:0]}, er);
    end
  endtask

  task automatic op_rand(input logic [63:0] x, input logic [63:0] y, input logic s);
    int n;
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rand_timeout: got no done expected done within 20 cycles");
    end
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = 64'h0000_0000_0000_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    int busy_n;
    int dn;
    int t1;
    int t2;

    // Reset state.
    #3;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", result, 64'(0));
    chk("rst_c_out", 64'(c_out), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Carry ripple across words.
    op_lit(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    // Full wrap and signed overflow.
    op_lit(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    op_lit(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    // Subtract.
    op_lit(64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    op_lit(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Start and operand changes during RUN are ignored.
    @(negedge clk);
    a = 64'h0001_0002_0003_0004; b = 64'h0010_0020_0030_0040; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_n++;
      if (done) begin
        dn++;
        chk("run_ignore_result", result, 64'h0011_0022_0033_0044);
      end
      if (i == 1) begin
        start = 1'b1; a = '1; b = '1; sub = 1'b1;
      end
      if (i == 2) start = 1'b0;
      @(negedge clk);
    end
    chk("run_ignore_busy_cycles", 64'(busy_n), 64'(WORDS));
    chk("run_ignore_done_pulses", 64'(dn), 64'(1));

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 64'h1234; b = 64'h1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_result", result, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    op_lit(64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0);

    // Back-to-back: start held across done.
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = i;
          chk("b2b_first", result, 64'h2345_6789_ABCD_F001);
          a = 64'h10; b = 64'h20; sub = 1'b1;
        end else if (t2 < 0) begin
          t2 = i;
          chk("b2b_second", result, 64'hFFFF_FFFF_FFFF_FFF0);
        end
      end
      if (t1 >= 0 && i == t1 + 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_gap", 64'(t2 - t1), 64'(WORDS + 1));

    // Random operations checked by the model.
    for (int i = 0; i < 1000; i++) begin
      op_rand(pick(), pick(), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
